// File: rtl/spi_slave_pkg.sv
// Shared constants and state encoding for the SPI responder.
package spi_slave_pkg;

  localparam int MODE_CPOL = 0;
  localparam int MODE_CPHA = 1;
  localparam int MODE_LSB  = 2;

  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Brings the asynchronous SCK/SSEL/MOSI pins into the system clock domain
// and produces single-cycle SCK edge and SSEL assertion strobes.
module spi_in_sync #(
  parameter int g_sync_stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck_pin,
  input  logic ssel_pin,
  input  logic mosi_pin,
  output logic sck_rise,
  output logic sck_fall,
  output logic ssel,
  output logic ssel_fall,
  output logic mosi
);

  logic [g_sync_stages-1:0] sck_sr;
  logic [g_sync_stages-1:0] ssel_sr;
  logic [g_sync_stages-1:0] mosi_sr;
  logic [g_sync_stages:0]   prime;
  logic                     sck_d;
  logic                     ssel_d;
  logic                     armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sr  <= '0;
      ssel_sr <= '1;
      mosi_sr <= '0;
      sck_d   <= 1'b0;
      ssel_d  <= 1'b1;
      prime   <= '0;
      armed   <= 1'b0;
    end else begin
      sck_sr  <= {sck_sr[g_sync_stages-2:0], sck_pin};
      ssel_sr <= {ssel_sr[g_sync_stages-2:0], ssel_pin};
      mosi_sr <= {mosi_sr[g_sync_stages-2:0], mosi_pin};
      sck_d   <= sck_sr[g_sync_stages-1];
      ssel_d  <= ssel_sr[g_sync_stages-1];
      prime   <= {prime[g_sync_stages-1:0], 1'b1};
      // The reset value of the SSEL chain is not a real deselect; only arm once
      // the chain holds genuine pin samples that show SSEL high.
      if (prime[g_sync_stages] && ssel_sr[g_sync_stages-1]) armed <= 1'b1;
    end
  end

  assign ssel      = ssel_sr[g_sync_stages-1];
  assign mosi      = mosi_sr[g_sync_stages-1];
  assign sck_rise  = sck_sr[g_sync_stages-1] & ~sck_d;
  assign sck_fall  = ~sck_sr[g_sync_stages-1] & sck_d;
  assign ssel_fall = armed & ssel_d & ~ssel_sr[g_sync_stages-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI responder with FIFO push/pull word interfaces; supports all CPOL/CPHA
// modes, either bit order and back-to-back words within one select.
//   state  | meaning
//   IDLE   | deselected; SCK edges ignored, MISO held at 0
//   ACTIVE | selected; shifting MOSI in and MISO out
module spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int g_word_width  = 32,
  parameter int g_sync_stages = DEFAULT_SYNC_STAGES
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cpol_i,
  input  logic                    cpha_i,
  input  logic                    lsb_first_i,
  input  logic                    spi_sck_i,
  input  logic                    spi_ssel_i,
  input  logic                    spi_mosi_i,
  output logic                    spi_miso_o,
  output logic                    spi_miso_oe_o,
  input  logic                    tx_empty_i,
  input  logic [g_word_width-1:0] tx_data_i,
  output logic                    tx_pull_o,
  input  logic                    rx_full_i,
  output logic [g_word_width-1:0] rx_data_o,
  output logic                    rx_push_o,
  output logic                    busy_o,
  output logic                    underrun_o,
  output logic                    overrun_o,
  output logic                    frame_err_o
);

  localparam int            CW       = $clog2(g_word_width);
  localparam logic [CW-1:0] LAST_BIT = CW'(g_word_width - 1);

  state_t                  state, state_nxt;
  logic [2:0]              mode;
  logic [CW-1:0]           bit_cnt;
  logic [g_word_width-1:0] rx_sr, tx_sr, rx_word, rx_next, tx_word;
  logic                    word_done, load_pend;
  logic                    sck_rise, sck_fall, ssel_s, ssel_fall, mosi_s;
  logic                    cpol, cpha, lsb, lead, trail;
  logic                    enter, leave, sample, shift, load;

  spi_in_sync #(.g_sync_stages(g_sync_stages)) u_sync (
    .clk       (clk_i),
    .rst       (reset_i),
    .sck_pin   (spi_sck_i),
    .ssel_pin  (spi_ssel_i),
    .mosi_pin  (spi_mosi_i),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .ssel      (ssel_s),
    .ssel_fall (ssel_fall),
    .mosi      (mosi_s)
  );

  assign cpol    = mode[MODE_CPOL];
  assign cpha    = mode[MODE_CPHA];
  assign lsb     = mode[MODE_LSB];
  assign lead    = cpol ? sck_fall : sck_rise;
  assign trail   = cpol ? sck_rise : sck_fall;
  assign tx_word = tx_empty_i ? '0 : tx_data_i;
  assign rx_next = lsb ? {mosi_s, rx_sr[g_word_width-1:1]}
                       : {rx_sr[g_word_width-2:0], mosi_s};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    enter         = 1'b0;
    leave         = 1'b0;
    sample        = 1'b0;
    shift         = 1'b0;
    load          = 1'b0;
    frame_err_o   = 1'b0;
    busy_o        = 1'b0;
    spi_miso_oe_o = 1'b0;
    case (state)
      IDLE: begin
        if (ssel_fall) begin
          state_nxt = ACTIVE;
          enter     = 1'b1;
          load      = ~cpha_i;
        end
      end
      ACTIVE: begin
        busy_o        = 1'b1;
        spi_miso_oe_o = 1'b1;
        if (ssel_s) begin
          state_nxt   = IDLE;
          leave       = 1'b1;
          frame_err_o = (bit_cnt != '0);
        end else begin
          sample = cpha ? trail : lead;
          shift  = cpha ? lead : trail;
          // cpha=1 fetches on the first leading edge of a word; cpha=0 fetches
          // on the shift edge that follows the previous word's last sample.
          load   = shift & (cpha ? (bit_cnt == '0) : load_pend);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode      <= '0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rx_word   <= '0;
      word_done <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (enter) begin
        mode[MODE_CPOL] <= cpol_i;
        mode[MODE_CPHA] <= cpha_i;
        mode[MODE_LSB]  <= lsb_first_i;
        bit_cnt         <= '0;
        rx_sr           <= '0;
        load_pend       <= 1'b0;
        tx_sr           <= cpha_i ? '0 : tx_word;
      end else if (leave) begin
        bit_cnt   <= '0;
        tx_sr     <= '0;
        load_pend <= 1'b0;
      end else begin
        if (sample) begin
          rx_sr <= rx_next;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt   <= '0;
            rx_word   <= rx_next;
            word_done <= 1'b1;
            load_pend <= ~cpha;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (shift) begin
          if (load) begin
            tx_sr     <= tx_word;
            load_pend <= 1'b0;
          end else begin
            tx_sr <= lsb ? (tx_sr >> 1) : (tx_sr << 1);
          end
        end
      end
    end
  end

  assign tx_pull_o  = load & ~tx_empty_i;
  assign underrun_o = load & tx_empty_i;
  assign rx_push_o  = word_done & ~rx_full_i;
  assign overrun_o  = word_done & rx_full_i;
  assign rx_data_o  = rx_word;
  assign spi_miso_o = lsb ? tx_sr[0] : tx_sr[g_word_width-1];

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
SPI responder (slave) with the same FIFO push/pull interface style as the existing SPI master, so the codebase can sit at the far end of an SPI link. It oversamples external SCK, SSEL and MOSI in the single system clock domain, then deserialises MOSI into words pushed to an RX FIFO. It serialises words pulled from a TX FIFO onto MISO. It supports all four CPOL/CPHA modes and continuous multi-word frames.

Parameters:
g_word_width, 32, bits per SPI word (8..32)
g_sync_stages, 2, synchronizer flops on each SPI input (>=2)

Ports:
clk_i  in  1  system clock; the single clock
reset_i  in  1  asynchronous, active-high reset
cpol_i  in  1  SCK idle level; latched at SSEL assertion
cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge; latched at SSEL assertion
lsb_first_i  in  1  bit order; latched at SSEL assertion
spi_sck_i  in  1  external SCK (asynchronous)
spi_ssel_i  in  1  external select, active low (asynchronous)
spi_mosi_i  in  1  external MOSI (asynchronous)
spi_miso_o  out  1  MISO data
spi_miso_oe_o  out  1  MISO output enable, 1 while selected
tx_empty_i  in  1  TX FIFO empty
tx_data_i  in  g_word_width  TX FIFO head word
tx_pull_o  out  1  one-cycle pull strobe
rx_full_i  in  1  RX FIFO full
rx_data_o  out  g_word_width  received word
rx_push_o  out  1  one-cycle push strobe
busy_o  out  1  frame in progress
underrun_o  out  1  one-cycle pulse: word needed, TX FIFO empty
overrun_o  out  1  one-cycle pulse: word dropped, RX FIFO full
frame_err_o  out  1  one-cycle pulse: SSEL released mid-word

Behaviour:
- Async reset (reset_i=1) clears all flops. Outputs after reset are all 0. Synchronizers reset to SCK=0, SSEL=1.
- Timing: inputs pass g_sync_stages flops plus one edge-detect flop. SCK frequency must be <= clk_i/8. SSEL-assert to first SCK edge must be >= 4 clk_i cycles.
- States: IDLE, ACTIVE.
  - IDLE -> ACTIVE on a synchronized SSEL high->low transition. On that transition, latch the mode inputs, clear bit_cnt, and set busy_o=1 and spi_miso_oe_o=1.
  - ACTIVE -> IDLE on synchronized SSEL high. Clear busy_o and spi_miso_oe_o, and drive spi_miso_o to 0.
  - After reset with SSEL already low, the block stays IDLE until SSEL goes high and then low again.
- Edges: leading edge = SCK leaving its idle level (cpol); trailing edge = SCK returning to it. Edges are ignored in IDLE.
- Sample edge: MOSI shifts into rx_sr (MSB-first: shift left, insert at bit 0; LSB-first: shift right, insert at MSB). bit_cnt increments and wraps at g_word_width-1 -> 0.
- Word complete: the sample edge with bit_cnt=g_word_width-1.
  - One cycle later, rx_data_o = rx_sr.
  - If rx_full_i=0, pulse rx_push_o. Otherwise pulse overrun_o and drop the word.
  - rx_data_o holds its value until the next completed word.
- TX load: take tx_data_i and pulse tx_pull_o if tx_empty_i=0. Otherwise load all-zero and pulse underrun_o.
  - cpha=0: load at ACTIVE entry, and on the first shift edge after each word complete; that edge loads instead of shifting.
  - cpha=1: load on every leading edge with bit_cnt=0.
  - All other shift edges shift tx_sr by one bit.
- MISO:
  - spi_miso_o = tx_sr[g_word_width-1] for MSB-first, tx_sr[0] for LSB-first, registered.
  - In cpha=1, MISO = 0 from ACTIVE entry until the first leading edge.
- SSEL release with bit_cnt!=0: pulse frame_err_o and discard the partial word; no push. An already pulled TX word is lost.
- Same-cycle tx_pull_o and rx_push_o is legal.
- Mode inputs changing mid-frame have no effect.
- Strobes are one cycle only. The FIFO interfaces are flow-through: a pull or push takes effect at the clock edge where the strobe is high.

Decomposition:
- Package spi_slave_pkg: mode bit positions, state encoding (IDLE=1'b0, ACTIVE=1'b1), default sync depth constant.
- Sub-module spi_in_sync: g_sync_stages synchronizer plus rise/fall edge detect for SCK, with synchronized SSEL and MOSI. It is instantiated once and carries the reset values above.

Test Plan:
- Mode 0, MSB-first, TX FIFO holds 0xA5A5_0F0F, master sends 0x1234_5678 -> MISO bits read 0xA5A5_0F0F; rx_push_o once with rx_data_o=0x1234_5678; tx_pull_o once.
- Mode 3, LSB-first, two continuous words 0xDEAD_BEEF and 0x0000_0001 with TX FIFO holding 0x8000_0000 and 0xFFFF_FFFF -> two pushes in order; MISO returns both words; no frame_err_o.
- TX FIFO empty at SSEL assert, mode 1 -> underrun_o one pulse; MISO all zero; RX word still pushed.
- rx_full_i=1 at word complete -> overrun_o one pulse; no rx_push_o; next word with rx_full_i=0 pushed normally.
- SSEL released after 13 of 32 bits -> frame_err_o one pulse; no push; next frame starts bit_cnt=0 and is received correctly.
- reset_i asserted mid-word with SSEL low -> all outputs 0 immediately; no activity until SSEL goes high then low; the following frame completes correctly.
